// File: rtl/circular_pkg.sv
// Shared types for the circular arc stepper: FSM state encoding, the signed unit-move
// type and the width of the midpoint error term.
package circular_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT,
        DONE
    } state_t;

    typedef logic signed [1:0] step_t;

    localparam int NUM_BITS_DEFAULT = 8;

    // Error term f = x^2 + y^2 - r^2 is evaluated with two guard bits over the squares.
    function automatic int err_bits(input int nb);
        return 2 * nb + 2;
    endfunction

    localparam int ERR_BITS = err_bits(NUM_BITS_DEFAULT);

endpackage

// File: rtl/circular_arc_stepper_move_sel.sv
// Combinational move chooser: fixes the primary-axis move from the octant, then picks the
// secondary move (-1/0/+1) giving the smallest |x'^2 + y'^2 - r^2|, ties to 0 then -1.
module circular_arc_stepper_move_sel
    import circular_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEFAULT,
    parameter int ERR_W    = ERR_BITS
) (
    input  logic signed [NUM_BITS-1:0] cur_x,
    input  logic signed [NUM_BITS-1:0] cur_y,
    input  logic        [NUM_BITS-1:0] r,
    input  logic                       is_cw,
    output step_t                      step_x,
    output step_t                      step_y
);

    localparam int CW = NUM_BITS + 1;

    logic signed [CW-1:0] x_e;
    logic signed [CW-1:0] y_e;
    logic        [CW-1:0] abs_x;
    logic        [CW-1:0] abs_y;
    logic                 x_primary;
    step_t                sgn_x;
    step_t                sgn_y;
    step_t                dp_ccw;
    step_t                dp;
    logic signed [CW-1:0] dp_e;
    logic signed [ERR_W-1:0] r_w;
    logic [2:0][ERR_W-1:0]   abs_f;
    step_t                sec_best;
    logic [ERR_W-1:0]     best_abs;

    assign x_e   = {cur_x[NUM_BITS-1], cur_x};
    assign y_e   = {cur_y[NUM_BITS-1], cur_y};
    assign abs_x = x_e[CW-1] ? -x_e : x_e;
    assign abs_y = y_e[CW-1] ? -y_e : y_e;
    assign x_primary = (abs_y >= abs_x);

    assign sgn_x = x_e[CW-1] ? 2'sb11 : ((x_e != '0) ? 2'sb01 : 2'sb00);
    assign sgn_y = y_e[CW-1] ? 2'sb11 : ((y_e != '0) ? 2'sb01 : 2'sb00);

    // Clockwise travel is the counter-clockwise primary move mirrored.
    assign dp_ccw = x_primary ? -sgn_y : sgn_x;
    assign dp     = is_cw ? -dp_ccw : dp_ccw;
    assign dp_e   = {{(CW-2){dp[1]}}, dp};
    assign r_w    = {{(ERR_W-NUM_BITS){1'b0}}, r};

    // Candidate gi carries secondary move gi-1.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            localparam step_t SEC = step_t'(gi - 1);
            logic signed [CW-1:0]    sec_e;
            logic signed [CW-1:0]    cand_x;
            logic signed [CW-1:0]    cand_y;
            logic signed [ERR_W-1:0] cx_w;
            logic signed [ERR_W-1:0] cy_w;
            logic signed [ERR_W-1:0] f;

            assign sec_e  = {{(CW-2){SEC[1]}}, SEC};
            assign cand_x = x_e + (x_primary ? dp_e : sec_e);
            assign cand_y = y_e + (x_primary ? sec_e : dp_e);
            assign cx_w   = {{(ERR_W-CW){cand_x[CW-1]}}, cand_x};
            assign cy_w   = {{(ERR_W-CW){cand_y[CW-1]}}, cand_y};
            assign f      = cx_w * cx_w + cy_w * cy_w - r_w * r_w;
            assign abs_f[gi] = f[ERR_W-1] ? -f : f;
        end
    endgenerate

    // Strict comparisons keep the earlier preference (0, then -1) on ties.
    always_comb begin
        sec_best = 2'sb00;
        best_abs = abs_f[1];
        if (abs_f[0] < best_abs) begin
            sec_best = 2'sb11;
            best_abs = abs_f[0];
        end
        if (abs_f[2] < best_abs) begin
            sec_best = 2'sb01;
        end
    end

    assign step_x = x_primary ? dp : sec_best;
    assign step_y = x_primary ? sec_best : dp;

endmodule

// File: rtl/circular_arc_stepper.sv
// Walks a centre-relative arc one unit move per output beat, then pulses done.
// Optional CIRCULAR_STEPPER_POS_OUT_EN exposes the current position as cur_x/cur_y.
module circular_arc_stepper
    import circular_pkg::*;
#(
    parameter int NUM_BITS  = NUM_BITS_DEFAULT,
    parameter int STEP_BITS = NUM_BITS + 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        is_cw,
    input  logic signed [NUM_BITS-1:0]  start_x,
    input  logic signed [NUM_BITS-1:0]  start_y,
    input  logic        [NUM_BITS-1:0]  r,
    input  logic        [STEP_BITS-1:0] num_steps,
    output logic                        out_valid,
    input  logic                        out_ready,
    output step_t                       step_x,
    output step_t                       step_y,
    output logic                        done
`ifdef CIRCULAR_STEPPER_POS_OUT_EN
    ,
    output logic signed [NUM_BITS-1:0]  cur_x,
    output logic signed [NUM_BITS-1:0]  cur_y
`endif
);

    state_t                      state_q, state_d;
    logic signed [NUM_BITS-1:0]  cur_x_q, cur_x_d;
    logic signed [NUM_BITS-1:0]  cur_y_q, cur_y_d;
    logic        [NUM_BITS-1:0]  r_q, r_d;
    logic                        cw_q, cw_d;
    logic        [STEP_BITS-1:0] cnt_q, cnt_d;
    step_t                       step_x_q, step_x_d;
    step_t                       step_y_q, step_y_d;
    step_t                       sel_x;
    step_t                       sel_y;

    circular_arc_stepper_move_sel #(
        .NUM_BITS (NUM_BITS),
        .ERR_W    (err_bits(NUM_BITS))
    ) u_move_sel (
        .cur_x  (cur_x_q),
        .cur_y  (cur_y_q),
        .r      (r_q),
        .is_cw  (cw_q),
        .step_x (sel_x),
        .step_y (sel_y)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            r_q      <= '0;
            cw_q     <= 1'b0;
            cnt_q    <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            r_q      <= r_d;
            cw_q     <= cw_d;
            cnt_q    <= cnt_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        r_d      = r_q;
        cw_d     = cw_q;
        cnt_d    = cnt_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cur_x_d = start_x;
                    cur_y_d = start_y;
                    r_d     = r;
                    cw_d    = is_cw;
                    cnt_d   = num_steps;
                    // Degenerate arcs skip straight to the done pulse.
                    state_d = (num_steps == '0 || r == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                step_x_d = sel_x;
                step_y_d = sel_y;
                state_d  = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    cur_x_d = cur_x_q + {{(NUM_BITS-2){step_x_q[1]}}, step_x_q};
                    cur_y_d = cur_y_q + {{(NUM_BITS-2){step_y_q[1]}}, step_y_q};
                    cnt_d   = cnt_q - STEP_BITS'(1);
                    state_d = (cnt_q == STEP_BITS'(1)) ? DONE : CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign done      = (state_q == DONE);
    assign step_x    = step_x_q;
    assign step_y    = step_y_q;

`ifdef CIRCULAR_STEPPER_POS_OUT_EN
    assign cur_x = cur_x_q;
    assign cur_y = cur_y_q;
`endif

endmodule

// File: tb/tb_circular_arc_stepper.sv
// Directed bench for circular_arc_stepper: short hand-worked arcs, backpressure,
// empty arcs, mid-arc reset and inputs presented while busy.
module tb_circular_arc_stepper;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_cw;
    logic [7:0]  start_x;
    logic [7:0]  start_y;
    logic [7:0]  r;
    logic [10:0] num_steps;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  step_x;
    logic [1:0]  step_y;
    logic        done;
`ifdef CIRCULAR_STEPPER_POS_OUT_EN
    logic [7:0]  cur_x;
    logic [7:0]  cur_y;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    circular_arc_stepper dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_cw     (is_cw),
        .start_x   (start_x),
        .start_y   (start_y),
        .r         (r),
        .num_steps (num_steps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_x    (step_x),
        .step_y    (step_y),
        .done      (done)
`ifdef CIRCULAR_STEPPER_POS_OUT_EN
        ,
        .cur_x     (cur_x),
        .cur_y     (cur_y)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller sits on a negedge in IDLE; the arc transfers on the following posedge.
    task automatic send_arc(input string tag, input logic cw, input logic [7:0] sx,
                            input logic [7:0] sy, input logic [7:0] rr, input logic [10:0] ns);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        is_cw     = cw;
        start_x   = sx;
        start_y   = sy;
        r         = rr;
        num_steps = ns;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        $display("arc %s: cw=%0d start=(%0d,%0d) r=%0d steps=%0d", tag, cw,
                 $signed(sx), $signed(sy), rr, ns);
    endtask

    task automatic wait_beat(input string tag, input logic [1:0] ex, input logic [1:0] ey);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < 8) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) found = 1'b1;
        end
        check({tag, "_latency"}, n, 32'd2);
        check({tag, "_step_x"}, {30'd0, step_x}, {30'd0, ex});
        check({tag, "_step_y"}, {30'd0, step_y}, {30'd0, ey});
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        $display("beat %s: step=(%0d,%0d) after %0d cycles", tag, $signed(step_x),
                 $signed(step_y), n);
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
        check({tag, "_no_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_done_clear"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        $display("done %s", tag);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        is_cw     = 1'b0;
        start_x   = '0;
        start_y   = '0;
        r         = '0;
        num_steps = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_step_x", {30'd0, step_x}, 32'd0);
        check("rst_step_y", {30'd0, step_y}, 32'd0);
`ifdef CIRCULAR_STEPPER_POS_OUT_EN
        check("rst_cur_x", {24'd0, cur_x}, 32'd0);
        check("rst_cur_y", {24'd0, cur_y}, 32'd0);
`endif
        reset = 1'b1;

        // CCW quarter from (2,0), r=2: (0,+1), (-1,+1), (-1,0)
        send_arc("t1", 1'b0, 8'd2, 8'd0, 8'd2, 11'd3);
        wait_beat("t1_b1", 2'b00, 2'b01);
`ifdef CIRCULAR_STEPPER_POS_OUT_EN
        check("t1_cur_x_start", {24'd0, cur_x}, 32'd2);
        check("t1_cur_y_start", {24'd0, cur_y}, 32'd0);
`endif
        wait_beat("t1_b2", 2'b11, 2'b01);
        wait_beat("t1_b3", 2'b11, 2'b00);
        check_done("t1");
`ifdef CIRCULAR_STEPPER_POS_OUT_EN
        check("t1_cur_x_end", {24'd0, cur_x}, 32'd0);
        check("t1_cur_y_end", {24'd0, cur_y}, 32'd2);
`endif

        // CW single step from (0,2): (+1,0)
        send_arc("t2", 1'b1, 8'd0, 8'd2, 8'd2, 11'd1);
        wait_beat("t2_b1", 2'b01, 2'b00);
        check_done("t2");

        // Backpressure on beat 2
        send_arc("t3", 1'b0, 8'd2, 8'd0, 8'd2, 11'd3);
        wait_beat("t3_b1", 2'b00, 2'b01);
        wait_beat("t3_b2", 2'b11, 2'b01);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_step_x", {30'd0, step_x}, 32'd3);
            check("t3_hold_step_y", {30'd0, step_y}, 32'd1);
        end
        out_ready = 1'b1;
        wait_beat("t3_b3", 2'b11, 2'b00);
        check_done("t3");

        // Empty arcs: zero steps, then zero radius
        send_arc("t4a", 1'b0, 8'd2, 8'd0, 8'd2, 11'd0);
        check_done("t4a");
        send_arc("t4b", 1'b0, 8'd2, 8'd0, 8'd0, 11'd5);
        check_done("t4b");

        // Reset mid-arc after the first beat transfers
        send_arc("t5", 1'b0, 8'd2, 8'd0, 8'd2, 11'd3);
        wait_beat("t5_b1", 2'b00, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_after_done", {31'd0, done}, 32'd0);
        check("t5_after_valid", {31'd0, out_valid}, 32'd0);
        send_arc("t5_new", 1'b1, 8'd0, 8'd2, 8'd2, 11'd1);
        wait_beat("t5_new_b1", 2'b01, 2'b00);
        check_done("t5_new");

        // New arc offered while busy is ignored
        send_arc("t6", 1'b0, 8'd2, 8'd0, 8'd2, 11'd3);
        wait_beat("t6_b1", 2'b00, 2'b01);
        is_cw     = 1'b1;
        start_x   = 8'd0;
        start_y   = 8'd2;
        num_steps = 11'd1;
        in_valid  = 1'b1;
        check("t6_busy_ready", {31'd0, in_ready}, 32'd0);
        wait_beat("t6_b2", 2'b11, 2'b01);
        wait_beat("t6_b3", 2'b11, 2'b00);
        in_valid = 1'b0;
        check_done("t6");
        @(negedge clk);
        check("t6_no_extra_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
